req_gen: RTL

REQ_GEN -- requirements
Module: req_gen

---
 rtl/req_gen_if.sv | 32 +++
 rtl/req_gen.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/req_gen_if.sv
// Handshake bundle between the two-channel request generator and its environment.
// slave: the req_gen side; master: the job source / downstream arbiter side.
interface req_gen_if;
  logic       i_job_0;
  logic       i_job_1;
  logic       i_gnt_0;
  logic       i_gnt_1;
  logic       o_req_0;
  logic       o_req_1;
  logic       o_busy_0;
  logic       o_busy_1;
  logic       o_done_0;
  logic       o_done_1;
  logic [3:0] o_pend_0;
  logic [3:0] o_pend_1;
  logic       o_ovf_0;
  logic       o_ovf_1;
  logic       o_timeout_0;
  logic       o_timeout_1;

  modport slave (
    input  i_job_0, i_job_1, i_gnt_0, i_gnt_1,
    output o_req_0, o_req_1, o_busy_0, o_busy_1, o_done_0, o_done_1,
           o_pend_0, o_pend_1, o_ovf_0, o_ovf_1, o_timeout_0, o_timeout_1
  );

  modport master (
    output i_job_0, i_job_1, i_gnt_0, i_gnt_1,
    input  o_req_0, o_req_1, o_busy_0, o_busy_1, o_done_0, o_done_1,
           o_pend_0, o_pend_1, o_ovf_0, o_ovf_1, o_timeout_0, o_timeout_1
  );
endinterface

// File: rtl/req_gen.sv
// Two independent job counters, each driving an IDLE/REQ/XFER/REL request FSM.
// Optional grant-timeout counter and sticky flag enabled by macro REQ_TIMEOUT_EN.
module req_gen #(
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned TIMEOUT   = 16
) (
  input logic     i_clk,
  input logic     i_rstn,
  req_gen_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_XFER,
    ST_REL
  } state_t;

  if (BURST_LEN < 1 || BURST_LEN > 15 || TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_param
    $error("req_gen: BURST_LEN must be 1..15 and TIMEOUT 2..255");
  end

  logic       w_job     [2];
  logic       w_gnt     [2];
  logic       w_req     [2];
  logic       w_busy    [2];
  logic       w_done    [2];
  logic       w_ovf     [2];
  logic       w_timeout [2];
  logic [3:0] w_pend    [2];

  assign w_job[0] = bus.i_job_0;
  assign w_job[1] = bus.i_job_1;
  assign w_gnt[0] = bus.i_gnt_0;
  assign w_gnt[1] = bus.i_gnt_1;

  assign bus.o_req_0     = w_req[0];
  assign bus.o_req_1     = w_req[1];
  assign bus.o_busy_0    = w_busy[0];
  assign bus.o_busy_1    = w_busy[1];
  assign bus.o_done_0    = w_done[0];
  assign bus.o_done_1    = w_done[1];
  assign bus.o_pend_0    = w_pend[0];
  assign bus.o_pend_1    = w_pend[1];
  assign bus.o_ovf_0     = w_ovf[0];
  assign bus.o_ovf_1     = w_ovf[1];
  assign bus.o_timeout_0 = w_timeout[0];
  assign bus.o_timeout_1 = w_timeout[1];

  for (genvar g = 0; g < 2; g++) begin : g_ch
    state_t     r_state;
    logic [3:0] r_pend;
    logic [3:0] r_burst;
    logic       r_done;
    logic       r_ovf;
    logic       w_last;
`ifdef REQ_TIMEOUT_EN
    logic [7:0] r_tocnt;
    logic       r_timeout;
`endif

    // Final beat of a burst that still holds the grant; completes the job.
    assign w_last = (r_state == ST_XFER) && w_gnt[g] && (r_burst == '0);

    always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
        r_state <= ST_IDLE;
        r_pend  <= '0;
        r_burst <= '0;
        r_done  <= 1'b0;
        r_ovf   <= 1'b0;
`ifdef REQ_TIMEOUT_EN
        r_tocnt   <= '0;
        r_timeout <= 1'b0;
`endif
      end else begin
        r_done <= w_last;

        // An enqueue that coincides with a completion frees its own slot.
        if (w_job[g] && !w_last) begin
          if (r_pend == '1) begin
            r_ovf <= 1'b1;
          end else begin
            r_pend <= r_pend + 4'd1;
          end
        end else if (w_last && !w_job[g]) begin
          r_pend <= r_pend - 4'd1;
        end

        case (r_state)
          ST_IDLE: begin
            if (r_pend != '0) begin
              r_state <= ST_REQ;
            end
          end
          ST_REQ: begin
            if (w_gnt[g]) begin
              r_state <= ST_XFER;
              r_burst <= 4'(BURST_LEN - 1);
            end
          end
          ST_XFER: begin
            if (!w_gnt[g] || (r_burst == '0)) begin
              r_state <= ST_REL;
            end else begin
              r_burst <= r_burst - 4'd1;
            end
          end
          ST_REL: begin
            if (!w_gnt[g]) begin
              r_state <= (r_pend != '0) ? ST_REQ : ST_IDLE;
            end
          end
          default: r_state <= ST_IDLE;
        endcase

`ifdef REQ_TIMEOUT_EN
        if ((r_state == ST_REQ) && !w_gnt[g]) begin
          if (r_tocnt != '1) begin
            r_tocnt <= r_tocnt + 8'd1;
          end
          if (r_tocnt >= 8'(TIMEOUT - 1)) begin
            r_timeout <= 1'b1;
          end
        end else begin
          r_tocnt <= '0;
        end
`endif
      end
    end

    assign w_req[g]  = (r_state == ST_REQ) || (r_state == ST_XFER);
    assign w_busy[g] = (r_state == ST_XFER);
    assign w_done[g] = r_done;
    assign w_pend[g] = r_pend;
    assign w_ovf[g]  = r_ovf;
`ifdef REQ_TIMEOUT_EN
    assign w_timeout[g] = r_timeout;
`else
    assign w_timeout[g] = 1'b0;
`endif
  end

endmodule
